// File: rtl/stoch_multi_gain_div.sv
// stoch_multi_gain_div: multi-channel stochastic divide-by-G (P(y)=P(a)/G) with runtime-loadable shared gain
// Ports: CLK/nRST clock and async active-low reset; a per-channel input bitstreams;
//        gain_in/gain_load gain load request; gain_busy high during the CLEAR cycle;
//        gain_err pulses when a zero gain was loaded; gain_q gain in effect; y output bitstreams.
module stoch_multi_gain_div #(
  parameter int CHANNELS     = 4,
  parameter int COUNTER_SIZE = 8,
  parameter int GAIN_WIDTH   = 4,
  parameter int DEFAULT_GAIN = 2,
  parameter bit REG_OUT      = 1'b0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CHANNELS-1:0]   a,
  input  logic [GAIN_WIDTH-1:0] gain_in,
  input  logic                  gain_load,
  output logic                  gain_busy,
  output logic                  gain_err,
  output logic [GAIN_WIDTH-1:0] gain_q,
  output logic [CHANNELS-1:0]   y
);
  localparam int AW = COUNTER_SIZE + GAIN_WIDTH + 1;
  localparam logic [AW-1:0] ALPHA = AW'((1 << COUNTER_SIZE) - 1);
  typedef enum logic {RUN, CLEAR} state_t;
  state_t state_q, state_d;
  logic [GAIN_WIDTH-1:0] gain_d;
  logic err_q, err_d;
  logic [AW-1:0] acc_q [CHANNELS];
  logic [AW-1:0] acc_d [CHANNELS];
  logic [AW-1:0] c [CHANNELS];
  logic [AW-1:0] thresh;
  logic [CHANNELS-1:0] y_int;
  assign gain_busy = state_q == CLEAR;
  assign gain_err = err_q;
  always_comb begin
    thresh = ALPHA * AW'(gain_q);
    state_d = gain_busy ? RUN : gain_load ? CLEAR : RUN;
    gain_d = (!gain_busy && gain_load) ? (gain_in == '0 ? GAIN_WIDTH'(1) : gain_in) : gain_q;
    err_d = !gain_busy && gain_load && gain_in == '0;
    y_int = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c[i] = acc_q[i] + (a[i] ? ALPHA : '0);
      y_int[i] = !gain_busy && c[i] >= thresh;
      // a load edge freezes the accumulators; CLEAR wipes them so the new gain starts clean
      acc_d[i] = gain_busy ? '0 : gain_load ? acc_q[i] : y_int[i] ? c[i] - thresh : c[i];
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      gain_q <= GAIN_WIDTH'(DEFAULT_GAIN);
      err_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gain_q <= gain_d;
      err_q <= err_d;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
    end
  end
  if (REG_OUT) begin : g_reg
    logic [CHANNELS-1:0] y_q;
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) y_q <= '0;
      else y_q <= y_int;
    end
    assign y = y_q;
  end else begin : g_comb
    // combinational output must still read 0 while reset is held
    assign y = nRST ? y_int : '0;
  end
endmodule
